pipeline_stall_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the write-enable, flush and hold controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses. A data-memory access is handled through a ready handshake with a bounded wait. The block sits beside the datapath and owns no data; it only decides which pipeline registers advance, hold or take a bubble each cycle.

---
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use, taken-branch flush, multi-cycle memory wait.
// Optional STALL_PERF_CNT_EN builds the saturating stall_cycles counter; otherwise stall_cycles is tied to 0.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_WriteRegister,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_hold,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned       WAIT_W       = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait_cnt;
  logic              w_mem_stall;
  logic              w_timeout;
  logic              w_load_use;

  assign w_load_use = ID_EX_MemRead && (ID_EX_WriteRegister != 5'd0) &&
                      ((ID_EX_WriteRegister == IF_ID_rs) || (ID_EX_WriteRegister == IF_ID_rt));

  // State and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Next state and Mealy controls; mem stall outranks branch, branch outranks load-use
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_mem_stall     = 1'b0;
    w_timeout       = 1'b0;
    PC_write        = 1'b1;
    IF_ID_write     = 1'b1;
    IF_ID_flush     = 1'b0;
    ID_EX_flush     = 1'b0;
    EX_MEM_hold     = 1'b0;
    MEM_WB_bubble   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          w_mem_stall     = 1'b1;
          w_next_state    = ST_MEM_WAIT;
          w_next_wait_cnt = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_next_state = ST_RUN;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          // forced release: the stall drops this cycle
          w_timeout    = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_mem_stall     = 1'b1;
          w_next_wait_cnt = r_wait_cnt + 1'b1;
        end
      end
      default: w_next_state = ST_RUN;
    endcase

    if (w_mem_stall) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      EX_MEM_hold   = 1'b1;
      MEM_WB_bubble = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (w_load_use) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  assign mem_timeout = w_timeout;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles in which the PC is frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!PC_write && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: priority table, directed multi-cycle sequences,
// and randomized traffic against a stall-accounting reference model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 8;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold, MEM_WB_bubble, mem_timeout}
  localparam logic [6:0] O_DEF = 7'b1100000;
  localparam logic [6:0] O_LU  = 7'b0001000;
  localparam logic [6:0] O_BR  = 7'b1111000;
  localparam logic [6:0] O_MS  = 7'b0000110;
  localparam logic [6:0] O_TO  = 7'b1100001;

  logic             clk = 1'b0;
  logic             reset;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_WriteRegister, IF_ID_rs, IF_ID_rt;
  logic             branch_taken, mem_req, mem_ready;
  logic             PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
  logic             EX_MEM_hold, MEM_WB_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0]       outs;

  int checks   = 0;
  int failures = 0;

  // reference model: whether an access is outstanding, and how many stall cycles it has cost
  bit m_in_access;
  int m_stalls;
  int m_cnt;

  always #5 clk = ~clk;

  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold, MEM_WB_bubble, mem_timeout};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteRegister(ID_EX_WriteRegister),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_hold(EX_MEM_hold), .MEM_WB_bubble(MEM_WB_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic       memrd;
    logic [4:0] wr, rs, rt;
    logic       br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic m, input logic [4:0] w, input logic [4:0] r,
                              input logic [4:0] t, input logic b, input logic q,
                              input logic y, input logic [6:0] e);
    vec_t v;
    v.memrd = m; v.wr = w; v.rs = r; v.rt = t;
    v.br = b; v.req = q; v.rdy = y; v.exp = e;
    return v;
  endfunction

  task automatic chk_outs(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: outs got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int exp);
    checks++;
    if (int'(stall_cycles) != exp) begin
      failures++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", nm, stall_cycles, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] w, input logic [4:0] r,
                       input logic [4:0] t, input logic b, input logic q, input logic y);
    ID_EX_MemRead = m; ID_EX_WriteRegister = w; IF_ID_rs = r; IF_ID_rt = t;
    branch_taken = b; mem_req = q; mem_ready = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_in_access = 1'b0;
    m_stalls    = 0;
    m_cnt       = 0;
  endtask

  // one clock with explicit expected outputs
  task automatic step(input logic b, input logic q, input logic y, input logic m,
                      input logic [6:0] exp, input string nm);
    @(negedge clk);
    drive(m, 5'd8, 5'd8, 5'd0, b, q, y);
    #1;
    chk_outs(nm, outs, exp);
    @(posedge clk);
  endtask

  // one clock checked against the reference model
  task automatic run_cycle(input logic m, input logic [4:0] w, input logic [4:0] r,
                           input logic [4:0] t, input logic b, input logic q, input logic y);
    bit lu, ms, to;
    logic [6:0] e;
    @(negedge clk);
    drive(m, w, r, t, b, q, y);
    lu = m && (w != 5'd0) && (w == r || w == t);
    if (m_in_access) begin
      ms = !y && (m_stalls < MEM_TIMEOUT);
      to = !y && (m_stalls >= MEM_TIMEOUT);
    end else begin
      ms = q && !y;
      to = 1'b0;
    end
    if (ms)      e = O_MS;
    else if (b)  e = O_BR;
    else if (lu) e = O_LU;
    else         e = O_DEF;
    e[0] = to;
    #1;
    chk_outs("rand_outs", outs, e);
    chk_cnt("rand_cnt", PERF ? m_cnt : 0);
    @(posedge clk);
    if (ms) begin
      m_in_access = 1'b1;
      m_stalls++;
    end else begin
      m_in_access = 1'b0;
      m_stalls    = 0;
    end
    if (!e[6] && m_cnt < CNT_MAX) m_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk_outs("reset_outs", outs, O_DEF);
    chk_cnt("reset_cnt", 0);
    @(negedge clk);
    reset = 1'b0;

    // priority table, all applied from RUN
    tbl[0]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF);
    tbl[1]  = mk(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, O_LU);
    tbl[2]  = mk(1, 5'd9, 5'd1, 5'd9, 0, 0, 0, O_LU);
    tbl[3]  = mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DEF);
    tbl[4]  = mk(0, 5'd8, 5'd8, 5'd8, 0, 0, 0, O_DEF);
    tbl[5]  = mk(1, 5'd8, 5'd3, 5'd4, 0, 0, 0, O_DEF);
    tbl[6]  = mk(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_BR);
    tbl[7]  = mk(1, 5'd8, 5'd8, 5'd0, 1, 0, 0, O_BR);
    tbl[8]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_MS);
    tbl[9]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_DEF);
    tbl[10] = mk(1, 5'd8, 5'd8, 5'd8, 1, 1, 0, O_MS);
    tbl[11] = mk(1, 5'd31, 5'd2, 5'd31, 0, 1, 1, O_LU);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].memrd, tbl[i].wr, tbl[i].rs, tbl[i].rt, tbl[i].br, tbl[i].req, tbl[i].rdy);
      #1;
      chk_outs($sformatf("table_%0d", i), outs, tbl[i].exp);
      #1;
      mem_req = 1'b0;
    end

    // load-use costs one bubble, then clears
    do_reset();
    step(0, 0, 0, 1, O_LU,  "lu_bubble");
    step(0, 0, 0, 0, O_DEF, "lu_clear");
    #1;
    chk_cnt("lu_cnt", PERF ? 1 : 0);

    // memory access with ready after 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, O_MS, $sformatf("mw_stall_%0d", i));
    step(0, 1, 1, 0, O_DEF, "mw_done");
    step(0, 0, 0, 0, O_DEF, "mw_run");
    #1;
    chk_cnt("mw_cnt", PERF ? 3 : 0);

    // timeout: MEM_TIMEOUT stall cycles then a one-cycle pulse
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, O_MS, $sformatf("to_stall_%0d", i));
    step(0, 1, 0, 0, O_TO,  "to_pulse");
    step(0, 0, 0, 0, O_DEF, "to_run");
    #1;
    chk_cnt("to_cnt", PERF ? 4 : 0);

    // ready in the timeout cycle is a normal completion
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, O_MS, $sformatf("tr_stall_%0d", i));
    step(0, 1, 1, 0, O_DEF, "tr_ready");
    step(0, 0, 0, 0, O_DEF, "tr_run");

    // branch held during a memory wait is serviced on release
    do_reset();
    step(1, 1, 0, 0, O_MS,  "bw_stall_0");
    step(1, 1, 0, 0, O_MS,  "bw_stall_1");
    step(1, 1, 1, 0, O_BR,  "bw_release");
    step(0, 0, 0, 0, O_DEF, "bw_run");

    // asynchronous reset on the second MEM_WAIT cycle
    do_reset();
    step(0, 1, 0, 0, O_MS, "rs_run_stall");
    step(0, 1, 0, 0, O_MS, "rs_wait1");
    @(negedge clk);
    drive(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk_outs("rs_wait2", outs, O_MS);
    #1;
    reset   = 1'b1;
    mem_req = 1'b0;
    #1;
    chk_outs("rs_async", outs, O_DEF);
    chk_cnt("rs_cnt", 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, O_DEF, "rs_run");

    // counter saturates at all-ones under a persistent load-use hazard
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (CNT_MAX + 40) @(posedge clk);
    #1;
    chk_cnt("sat_cnt", PERF ? CNT_MAX : 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
